// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready handshake, one-entry skid buffer, stall and flush.
// Optional perf counters (stall/flush/bubble) are built only when PIPE_STAGE_PERF_EN is defined.
//
// state    | meaning
// ST_EMPTY | no entry held
// ST_HALF  | head (main) register holds an entry
// ST_FULL  | main and skid both hold entries; upstream is back-pressured
module pipe_stage_skid #(
    parameter int CTRL_W         = 3,
    parameter int DATA_W         = 101,
    parameter int FLUSH_CLR_DATA = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              main_valid, skid_valid, accept, emit;

    always_comb begin
        main_valid = (state_q != ST_EMPTY);
        skid_valid = (state_q == ST_FULL);
        in_ready   = !rst && !flush && !stall && (state_q != ST_FULL);
        out_valid  = !rst && main_valid && !flush && !stall;
        out_ctrl   = out_valid ? main_ctrl_q : '0;
        out_data   = main_data_q;
        occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
        accept     = in_valid && in_ready;
        emit       = out_valid && out_ready;
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (FLUSH_CLR_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            // stall forces accept/emit low, so every branch below simply holds
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_HALF;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_HALF: begin
                    if (accept && emit) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (emit) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_d     = ST_HALF;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // counters saturate at all-ones rather than wrapping
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (!out_valid && out_ready && !stall && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
